// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU: datapath width, funct3 codes and a
// bit-reversal helper used to run left shifts through a right shifter.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNC_ADD  = 3'b000;
    localparam logic [2:0] FUNC_SLL  = 3'b001;
    localparam logic [2:0] FUNC_SLT  = 3'b010;
    localparam logic [2:0] FUNC_SLTU = 3'b011;
    localparam logic [2:0] FUNC_XOR  = 3'b100;
    localparam logic [2:0] FUNC_SR   = 3'b101;
    localparam logic [2:0] FUNC_OR   = 3'b110;
    localparam logic [2:0] FUNC_AND  = 3'b111;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] value);
        logic [XLEN-1:0] reversed;
        for (int i = 0; i < XLEN; i++) begin
            reversed[i] = value[XLEN-1-i];
        end
        return reversed;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit logarithmic barrel shifter serving SLL, SRL and SRA.
// direction=1 shifts right; arithmetic=1 fills right shifts with data[31].
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    input  logic            direction,
    input  logic            arithmetic,
    output logic [XLEN-1:0] shifted
);

    logic            fill;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] stage_1;
    logic [XLEN-1:0] stage_2;
    logic [XLEN-1:0] stage_4;
    logic [XLEN-1:0] stage_8;
    logic [XLEN-1:0] stage_16;

    // Left shifts reuse the right-shift stages on a bit-reversed operand.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so each stage sees the
        // value computed just above it in the same evaluation.
        fill     = arithmetic & direction & data[XLEN-1];
        src      = direction ? data : bit_reverse(data);
        stage_1  = shamt[0] ? {{1{fill}},  src[XLEN-1:1]}       : src;
        stage_2  = shamt[1] ? {{2{fill}},  stage_1[XLEN-1:2]}   : stage_1;
        stage_4  = shamt[2] ? {{4{fill}},  stage_2[XLEN-1:4]}   : stage_2;
        stage_8  = shamt[3] ? {{8{fill}},  stage_4[XLEN-1:8]}   : stage_4;
        stage_16 = shamt[4] ? {{16{fill}}, stage_8[XLEN-1:16]}  : stage_8;
        shifted  = direction ? stage_16 : bit_reverse(stage_16);
    end

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU: funct3-selected operation with control picking
// LUI/SRA, captured into a single result register (one cycle of latency).
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    input  logic [2:0]      func,
    input  logic            control,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] result_next;
    logic            signed_lt;
    logic            unsigned_lt;

    alu_shifter u_shifter (
        .data       (operand_A),
        .shamt      (operand_B[4:0]),
        .direction  (func == FUNC_SR),
        .arithmetic (control),
        .shifted    (shifted)
    );

    assign signed_lt   = $signed(operand_A) < $signed(operand_B);
    assign unsigned_lt = operand_A < operand_B;

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // result_next unassigned and infers a latch.
        result_next = '0;
        case (func)
            FUNC_ADD:  result_next = control ? operand_B : operand_A + operand_B;
            FUNC_SLL:  result_next = shifted;
            FUNC_SLT:  result_next = {{(XLEN-1){1'b0}}, signed_lt};
            FUNC_SLTU: result_next = {{(XLEN-1){1'b0}}, unsigned_lt};
            FUNC_XOR:  result_next = operand_A ^ operand_B;
            FUNC_SR:   result_next = shifted;
            FUNC_OR:   result_next = operand_A | operand_B;
            FUNC_AND:  result_next = operand_A & operand_B;
            default:   result_next = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<='; the async reset clears
    // the register at once so a pending result never survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else begin
            result <= result_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: table vectors streamed one per cycle through a
// scoreboard queue, random vectors against a reference model, reset corners.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [2:0]  func;
    logic        control;
    logic [31:0] result;

    int n_checks;
    int n_passed;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  func;
        logic        ctrl;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    vec_t      vecs[$];
    sb_entry_t sb[$];

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .func      (func),
        .control   (control),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic c);
        logic [31:0] r;
        case (f)
            3'd0: r = c ? b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = c ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic c);
        operand_A = a;
        operand_B = b;
        func      = f;
        control   = c;
    endtask

    // One vector per cycle: at each falling edge, retire the result captured
    // on the previous rising edge, then drive the next vector.
    task automatic run_stream();
        sb_entry_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, result, e.exp);
            end
            drive(vecs[i].a, vecs[i].b, vecs[i].func, vecs[i].ctrl);
            sb.push_back('{vecs[i].name, vecs[i].exp});
        end
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, result, e.exp);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;
        logic        rc;

        n_checks = 0;
        n_passed = 0;

        vecs.push_back('{"add_wrap",   32'hFFFFFFFF, 32'h00000001, 3'b000, 1'b0, 32'h00000000});
        vecs.push_back('{"add_simple", 32'h00000001, 32'h00000001, 3'b000, 1'b0, 32'h00000002});
        vecs.push_back('{"lui",        32'h00000001, 32'h00FF0000, 3'b000, 1'b1, 32'h00FF0000});
        vecs.push_back('{"sll_2",      32'h00000002, 32'h00000001, 3'b001, 1'b0, 32'h00000004});
        vecs.push_back('{"sll_ones",   32'hFFFFFFFF, 32'h00000001, 3'b001, 1'b0, 32'hFFFFFFFE});
        vecs.push_back('{"srl_21",     32'hAAAAAAAA, 32'h55555555, 3'b101, 1'b0, 32'h00000555});
        vecs.push_back('{"sra_21",     32'hAAAAAAAA, 32'h55555555, 3'b101, 1'b1, 32'hFFFFFD55});
        vecs.push_back('{"sra_shamt0", 32'h800000FF, 32'h00FF0000, 3'b101, 1'b1, 32'h800000FF});
        vecs.push_back('{"sll_ctrl1",  32'h00000003, 32'hFFFFFFE4, 3'b001, 1'b1, 32'h00000030});
        vecs.push_back('{"slt_neg",    32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b0, 32'h00000001});
        vecs.push_back('{"sltu_big",   32'hFFFFFFFF, 32'h00000001, 3'b011, 1'b0, 32'h00000000});
        vecs.push_back('{"slt_eq",     32'h00000001, 32'h00000001, 3'b010, 1'b0, 32'h00000000});
        vecs.push_back('{"sltu_eq",    32'h00000001, 32'h00000001, 3'b011, 1'b0, 32'h00000000});
        vecs.push_back('{"sltu_lt",    32'h00000001, 32'h80000000, 3'b011, 1'b1, 32'h00000001});
        vecs.push_back('{"xor",        32'hAAAAAAAA, 32'h55555555, 3'b100, 1'b0, 32'hFFFFFFFF});
        vecs.push_back('{"or",         32'hAAAAAAAA, 32'h55555555, 3'b110, 1'b0, 32'hFFFFFFFF});
        vecs.push_back('{"and_zero",   32'hAAAAAAAA, 32'h55555555, 3'b111, 1'b0, 32'h00000000});
        vecs.push_back('{"and_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0, 32'hFFFFFFFF});
        vecs.push_back('{"or_ctrl1",   32'h12340000, 32'h00005678, 3'b110, 1'b1, 32'h12345678});
        vecs.push_back('{"or_ctrl0",   32'h12340000, 32'h00005678, 3'b110, 1'b0, 32'h12345678});
        vecs.push_back('{"srl_31",     32'h80000000, 32'h0000001F, 3'b101, 1'b0, 32'h00000001});
        vecs.push_back('{"sra_31",     32'h80000000, 32'h0000001F, 3'b101, 1'b1, 32'hFFFFFFFF});

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rf = 3'($urandom_range(0, 7));
            rc = 1'($urandom_range(0, 1));
            vecs.push_back('{$sformatf("rand_%0d_f%0d_c%0d", i, rf, rc), ra, rb, rf, rc,
                             model(ra, rb, rf, rc)});
        end

        // Reset held with nonzero operands and a running clock.
        rst_n = 1'b0;
        drive(32'h00000005, 32'h00000006, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", result, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", result, 32'h0000000B);

        run_stream();

        // Asynchronous reset mid-cycle drops result before the next edge.
        @(negedge clk);
        drive(32'h00000001, 32'h00000001, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        check("pre_async_reset", result, 32'h00000002);
        drive(32'hAAAAAAAA, 32'h55555555, 3'b100, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_midcycle", result, 32'h0);
        @(posedge clk);
        #1;
        check("reset_held_edge", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("capture_after_reset", result, 32'hFFFFFFFF);

        // Inputs changing between edges only matter at the next edge.
        @(negedge clk);
        drive(32'h00000010, 32'h00000004, 3'b001, 1'b0);
        #2;
        check("no_change_between_edges", result, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        check("sll_after_edge", result, 32'h00000100);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
